pht_ctrl: RTL and testbench
===========================

PHT_CTRL -- requirements
Module: pht_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 6, table index width (DEPTH = 2^IDX_W entries).
REQ-002 SHALL have parameter Q_DEPTH, default 4, update-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_req  input  1  one-cycle pulse, reinitialise table.
REQ-006 SHALL have port pred_req  input  1  prediction lookup request.
REQ-007 SHALL have port pred_index  input  IDX_W  lookup index.
REQ-008 SHALL have port pred_resp_valid  output  1  response valid, one cycle after pred_req.
REQ-009 SHALL have port pred_taken  output  1  predicted direction (= pred_state[1]).
REQ-010 SHALL have port pred_state  output  2  counter value of looked-up entry.
REQ-011 SHALL have port upd_valid  input  1  resolved-branch update offered.
REQ-012 SHALL have port upd_index  input  IDX_W  entry to train.
REQ-013 SHALL have port upd_taken  input  1  actual outcome, 1 = taken.
REQ-014 SHALL have port upd_ready  output  1  queue can accept; transfer on upd_valid && upd_ready at rising edge.
REQ-015 SHALL have port busy  output  1  init sweep in progress.

Function
REQ-016 SHALL hold DEPTH 2-bit counters, encoding SNT=00, WNT=01, WT=10, ST=11; saturating transitions: taken increments to ST max, not-taken decrements to SNT min.
REQ-017 SHALL implement FSM states INIT and RUN; INIT writes WNT to entry sweep_idx each cycle, sweep_idx 0..DEPTH-1; after writing DEPTH-1, next state RUN.
REQ-018 SHALL, on flush_req in RUN, enter INIT with sweep_idx=0, clear the queue, discard both pipeline stages; flush_req in INIT restarts sweep at 0 and clears the queue.
REQ-019 SHALL assert busy exactly while in INIT.
REQ-020 SHALL drive pred_resp_valid=1 in the cycle after any pred_req, in both states; in INIT response is pred_state=01, pred_taken=0.
REQ-021 SHALL, in RUN, return the entry value including any table write committed at the same edge that registers the request (write-before-read bypass).
REQ-022 SHALL drive upd_ready = (queue count < Q_DEPTH), independent of FSM state, from registered count only; push and pop allowed same cycle when not full.
REQ-023 SHALL pop at most one queue entry per cycle, only in RUN, into stage S1 (read old counter); S2 computes next value and writes table.
REQ-024 SHALL forward S2's next value to S1 when indices match, so consecutive same-index updates chain correctly.
REQ-025 SHALL, with empty queue in RUN, write table 2 edges after the accept edge; sustained throughput one update per cycle.
REQ-026 SHALL buffer updates accepted during INIT and apply them in order after RUN entry.

Reset
REQ-027 SHALL, on resetn low, asynchronously set: state INIT, sweep_idx 0, queue empty, S1/S2 invalid, pred_resp_valid 0, pred_taken 0, pred_state 01, busy 1, upd_ready 1.
REQ-028 SHALL not reset the counter array; the INIT sweep initialises it (DEPTH cycles after resetn rises).

Structure
REQ-029 SHALL take counter encodings (SNT/WNT/WT/ST), NT/T action constants and the FSM state typedef from shared package bp_pkg.
REQ-030 SHALL instantiate counter2 (2-bit saturating next-state block) once, in S2.
REQ-031 SHALL implement queue as internal circular buffer; no further sub-modules.

Verification
REQ-032 SHALL cover reset release: busy=1 for 64 cycles; pred idx 5 during INIT -> state 01, taken 0; after busy falls idx 5 -> 01.
REQ-033 SHALL cover saturation: idx 3 trained T,T,T -> 10,11,11, pred_taken=1; then NT,NT,NT -> 10,01,00.
REQ-034 SHALL cover back-to-back: idx 7 T on consecutive cycles from 01 -> final 11 (forwarding), never stuck at 10.
REQ-035 SHALL cover full queue: 5 updates offered during INIT -> upd_ready 0 after 4th accept, 5th held; after RUN, drains one per cycle, all 5 applied in order.
REQ-036 SHALL cover mid-run flush: idx 2 at 11, 2 updates queued, flush_req -> busy 64 cycles, queued updates discarded, idx 2 reads 01.
REQ-037 SHALL cover bypass: pred_req idx 9 on the cycle S2 writes idx 9 from 01 with T -> response state 10.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor encodings and FSM state type
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic NT = 1'b0;
  localparam logic T  = 1'b1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_e;

endpackage

// File: rtl/counter2.sv
// rtl/counter2.sv - 2-bit saturating counter next-state
module counter2
  import bp_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  always_comb begin
    o_next = i_cnt;
    if (i_taken == T) begin
      if (i_cnt != ST) o_next = i_cnt + 2'd1;
    end else if (i_taken == NT) begin
      if (i_cnt != SNT) o_next = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// rtl/pht_ctrl.sv - pattern history table with init sweep, update queue and 2-stage train pipeline
module pht_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int Q_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_req,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_index,
  output logic             pred_resp_valid,
  output logic             pred_taken,
  output logic [1:0]       pred_state,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int QA_W  = $clog2(Q_DEPTH);
  localparam int CNT_W = QA_W + 1;

  pht_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx, w_sweep_nxt;
  logic [1:0]       r_table [DEPTH];

  logic [IDX_W-1:0] r_q_idx [Q_DEPTH];
  logic [Q_DEPTH-1:0] r_q_tk;
  logic [QA_W-1:0]  r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;
  logic [IDX_W-1:0] w_pop_idx;
  logic [1:0]       w_pop_old;

  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_tk;
  logic [1:0]       r_s1_old;
  logic [1:0]       w_s2_next;

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       w_wr_data;

  logic             r_pred_valid;
  logic [1:0]       r_pred_state;

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    case (r_state)
      INIT: begin
        if (flush_req) begin
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_idx + IDX_W'(1);
          if (r_sweep_idx == IDX_W'(DEPTH - 1)) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush_req) begin
          w_state_nxt = INIT;
          w_sweep_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_sweep_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  // S2: next counter value from the S1 snapshot; a flush at the same edge drops the write
  counter2 u_counter2 (
    .i_cnt   (r_s1_old),
    .i_taken (r_s1_tk),
    .o_next  (w_s2_next)
  );

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_s1_idx;
    w_wr_data = w_s2_next;
    if (r_state == INIT) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_sweep_idx;
      w_wr_data = WNT;
    end else if (r_s1_valid && !flush_req) begin
      w_wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_table[w_wr_idx] <= w_wr_data;
  end

  assign upd_ready = (r_cnt < CNT_W'(Q_DEPTH));
  assign w_push    = upd_valid && upd_ready;
  assign w_pop     = (r_state == RUN) && (r_cnt != '0) && !flush_req;
  assign w_pop_idx = r_q_idx[r_rp];
  // Entry ahead in S2 writes at the pop edge, so its result is forwarded instead of the stale table
  assign w_pop_old = (r_s1_valid && (r_s1_idx == w_pop_idx)) ? w_s2_next : r_table[w_pop_idx];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wp] <= upd_index;
      r_q_tk[r_wp]  <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush_req) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + QA_W'(1);
      if (w_pop)  r_rp <= r_rp + QA_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_tk    <= 1'b0;
      r_s1_old   <= WNT;
    end else begin
      r_s1_valid <= w_pop;
      if (w_pop) begin
        r_s1_idx <= w_pop_idx;
        r_s1_tk  <= r_q_tk[r_rp];
        r_s1_old <= w_pop_old;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pred_valid <= 1'b0;
      r_pred_state <= WNT;
    end else begin
      r_pred_valid <= pred_req;
      if (pred_req) begin
        if (r_state == INIT)
          r_pred_state <= WNT;
        else if (w_wr_en && (w_wr_idx == pred_index))
          r_pred_state <= w_wr_data;
        else
          r_pred_state <= r_table[pred_index];
      end
    end
  end

  assign pred_resp_valid = r_pred_valid;
  assign pred_state      = r_pred_state;
  assign pred_taken      = r_pred_state[1];
  assign busy            = (r_state == INIT);

endmodule

// File: tb/tb_pht_ctrl.sv
// tb/tb_pht_ctrl.sv - directed table-driven bench for pht_ctrl
module tb_pht_ctrl;

  localparam int IDX_W   = 6;
  localparam int Q_DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush_req = 1'b0;
  logic             pred_req = 1'b0;
  logic [IDX_W-1:0] pred_index = '0;
  logic             pred_resp_valid;
  logic             pred_taken;
  logic [1:0]       pred_state;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_index = '0;
  logic             upd_taken = 1'b0;
  logic             upd_ready;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pht_ctrl #(.IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush_req       (flush_req),
    .pred_req        (pred_req),
    .pred_index      (pred_index),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .pred_state      (pred_state),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .upd_ready       (upd_ready),
    .busy            (busy)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             tk;
    logic [1:0]       exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic predict(input logic [IDX_W-1:0] idx, input logic [1:0] exp, input string name);
    pred_req   = 1'b1;
    pred_index = idx;
    tick();
    pred_req = 1'b0;
    check({name, ".valid"}, 8'(pred_resp_valid), 8'd1);
    check({name, ".state"}, 8'(pred_state), 8'(exp));
    check({name, ".taken"}, 8'(pred_taken), 8'(exp[1]));
  endtask

  task automatic update(input logic [IDX_W-1:0] idx, input logic tk, input string name);
    int guard = 0;
    while (!upd_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({name, ".ready"}, 8'(upd_ready), 8'd1);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = tk;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [IDX_W-1:0] qi [5];
    logic             qt [5];

    vecs[0]  = '{6'd3,  1'b1, 2'b10};
    vecs[1]  = '{6'd3,  1'b1, 2'b11};
    vecs[2]  = '{6'd3,  1'b1, 2'b11};
    vecs[3]  = '{6'd3,  1'b0, 2'b10};
    vecs[4]  = '{6'd3,  1'b0, 2'b01};
    vecs[5]  = '{6'd3,  1'b0, 2'b00};
    vecs[6]  = '{6'd20, 1'b0, 2'b00};
    vecs[7]  = '{6'd20, 1'b0, 2'b00};
    vecs[8]  = '{6'd20, 1'b1, 2'b01};
    vecs[9]  = '{6'd40, 1'b1, 2'b10};
    vecs[10] = '{6'd40, 1'b0, 2'b01};
    vecs[11] = '{6'd63, 1'b1, 2'b10};
    vecs[12] = '{6'd0,  1'b0, 2'b00};

    qi[0] = 6'd11; qt[0] = 1'b1;
    qi[1] = 6'd12; qt[1] = 1'b0;
    qi[2] = 6'd11; qt[2] = 1'b1;
    qi[3] = 6'd11; qt[3] = 1'b1;
    qi[4] = 6'd11; qt[4] = 1'b0;

    tick();
    tick();
    check("rst.busy",  8'(busy), 8'd1);
    check("rst.ready", 8'(upd_ready), 8'd1);
    check("rst.valid", 8'(pred_resp_valid), 8'd0);
    check("rst.state", 8'(pred_state), 8'd1);
    check("rst.taken", 8'(pred_taken), 8'd0);

    resetn = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      pred_req   = (n == 10);
      pred_index = 6'd5;
      if (n == 11) begin
        check("init.valid", 8'(pred_resp_valid), 8'd1);
        check("init.state", 8'(pred_state), 8'd1);
        check("init.taken", 8'(pred_taken), 8'd0);
      end
      tick();
      n++;
    end
    pred_req = 1'b0;
    check("init.busy_cycles", 8'(n), 8'd64);
    predict(6'd5, 2'b01, "post_init");

    for (int i = 0; i < 13; i++) begin
      update(vecs[i].idx, vecs[i].tk, $sformatf("vec%0d", i));
      tick();
      tick();
      predict(vecs[i].idx, vecs[i].exp, $sformatf("vec%0d", i));
    end

    upd_valid = 1'b1;
    upd_index = 6'd7;
    upd_taken = 1'b1;
    tick();
    check("b2b.ready", 8'(upd_ready), 8'd1);
    tick();
    upd_valid = 1'b0;
    repeat (3) tick();
    predict(6'd7, 2'b11, "b2b");

    upd_valid = 1'b1;
    upd_index = 6'd9;
    upd_taken = 1'b1;
    tick();
    upd_valid  = 1'b0;
    pred_req   = 1'b1;
    pred_index = 6'd9;
    tick();
    check("byp.early", 8'(pred_state), 8'd1);
    tick();
    pred_req = 1'b0;
    check("byp.valid", 8'(pred_resp_valid), 8'd1);
    check("byp.state", 8'(pred_state), 8'd2);
    check("byp.taken", 8'(pred_taken), 8'd1);

    update(6'd2, 1'b1, "fl.a");
    update(6'd2, 1'b1, "fl.b");
    repeat (3) tick();
    predict(6'd2, 2'b11, "fl.pre");
    upd_valid = 1'b1;
    upd_index = 6'd2;
    upd_taken = 1'b0;
    tick();
    tick();
    upd_valid = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_busy(n);
    check("fl.busy_cycles", 8'(n), 8'd64);
    repeat (3) tick();
    predict(6'd2, 2'b01, "fl.idx2");
    predict(6'd3, 2'b01, "fl.idx3");

    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("q.busy", 8'(busy), 8'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("q.ready%0d", k), 8'(upd_ready), 8'd1);
      upd_valid = 1'b1;
      upd_index = qi[k];
      upd_taken = qt[k];
      tick();
    end
    upd_index = qi[4];
    upd_taken = qt[4];
    check("q.full", 8'(upd_ready), 8'd0);
    repeat (3) tick();
    check("q.held", 8'(upd_ready), 8'd0);
    wait_busy(n);
    check("q.run_entry_ready", 8'(upd_ready), 8'd0);
    tick();
    check("q.drain_ready", 8'(upd_ready), 8'd1);
    tick();
    upd_valid = 1'b0;
    repeat (3) tick();
    predict(6'd11, 2'b10, "q.timed_idx11");
    repeat (4) tick();
    predict(6'd11, 2'b10, "q.idx11");
    predict(6'd12, 2'b00, "q.idx12");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
